// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//   Two-bit saturating-counter branch history table with a direct-mapped
//   target buffer. IF looks it up combinationally; ID trains it once a
//   branch has resolved, flags mispredicts and keeps performance counters.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   pc_IF                 fetch PC for lookup
//   pred_taken_IF         predicted taken
//   pred_target_IF        predicted target, 0 when not taken
//   upd_en_ID, stall_ID   resolved-branch strobe, ID stall (gates update)
//   pc_ID, taken_ID, target_ID            resolved branch
//   pred_taken_ID, pred_target_ID         prediction carried with the branch
//   mispredict_ID         redirect fetch (combinational)
//   redirect_pc_ID        correct next PC
//   br_cnt, mp_cnt        resolved-branch / mispredict counters (wrap)
module branch_predictor_bht #(
  parameter int IDX_W = 4,
  parameter int PC_W  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_IF,
  output logic            pred_taken_IF,
  output logic [PC_W-1:0] pred_target_IF,
  input  logic            upd_en_ID,
  input  logic            stall_ID,
  input  logic [PC_W-1:0] pc_ID,
  input  logic            taken_ID,
  input  logic [PC_W-1:0] target_ID,
  input  logic            pred_taken_ID,
  input  logic [PC_W-1:0] pred_target_ID,
  output logic            mispredict_ID,
  output logic [PC_W-1:0] redirect_pc_ID,
  output logic [15:0]     br_cnt,
  output logic [15:0]     mp_cnt
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = PC_W - IDX_W - 2;

  logic              valid_q [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [1:0]        ctr_q   [DEPTH];
  logic [PC_W-1:0]   tgt_q   [DEPTH];

  logic [IDX_W-1:0]  idx_if, idx_id;
  logic [TAG_W-1:0]  tag_if, tag_id;
  logic              hit_if, hit_id;
  logic              upd;

  // Word-aligned PCs: the low two bits never participate.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_IF[1:0], pc_ID[1:0]};

  assign idx_if = pc_IF[IDX_W+1:2];
  assign tag_if = pc_IF[PC_W-1:IDX_W+2];
  assign idx_id = pc_ID[IDX_W+1:2];
  assign tag_id = pc_ID[PC_W-1:IDX_W+2];

  // Lookup reads the registered table only, so a same-cycle update to the
  // same index is not visible until the following cycle.
  assign hit_if         = valid_q[idx_if] && (tag_q[idx_if] == tag_if);
  assign pred_taken_IF  = hit_if && ctr_q[idx_if][1];
  assign pred_target_IF = pred_taken_IF ? tgt_q[idx_if] : '0;

  assign upd    = upd_en_ID && !stall_ID;
  assign hit_id = valid_q[idx_id] && (tag_q[idx_id] == tag_id);

  assign mispredict_ID  = upd && ((taken_ID != pred_taken_ID) ||
                                  (taken_ID && (pred_target_ID != target_ID)));
  assign redirect_pc_ID = taken_ID ? target_ID : (pc_ID + PC_W'(4));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
        tgt_q[i]   <= '0;
      end
    end else if (upd) begin
      if (hit_id) begin
        if (taken_ID) begin
          if (ctr_q[idx_id] != 2'b11) ctr_q[idx_id] <= ctr_q[idx_id] + 2'd1;
          tgt_q[idx_id] <= target_ID;
        end else if (ctr_q[idx_id] != 2'b00) begin
          ctr_q[idx_id] <= ctr_q[idx_id] - 2'd1;
        end
      end else if (taken_ID) begin
        // Allocate on a taken miss, evicting whatever aliased here.
        valid_q[idx_id] <= 1'b1;
        tag_q[idx_id]   <= tag_id;
        ctr_q[idx_id]   <= 2'b10;
        tgt_q[idx_id]   <= target_ID;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (upd) begin
      br_cnt <= br_cnt + 16'd1;
      if (mispredict_ID) mp_cnt <= mp_cnt + 16'd1;
    end
  end

endmodule

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
- Two-bit saturating-counter branch history table with a direct-mapped target buffer.
- The IF stage looks it up combinationally with the fetch PC to get a predicted direction and target.
- The ID stage trains it once a branch (op 3'b110) has resolved. Resolution happens after ID-stage forwarding and stall handling has delivered valid operands.
- The ID stage also flags a mispredict so the front end can redirect, and the block keeps branch and mispredict counters for performance readout.

Parameters:
- IDX_W, 4: index width; the table has 2**IDX_W entries.
- PC_W, 32: PC and target width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_IF  in  PC_W  fetch PC for lookup
- pred_taken_IF  out  1  predicted taken
- pred_target_IF  out  PC_W  predicted target; 0 when not taken
- upd_en_ID  in  1  branch in ID has resolved this cycle
- stall_ID  in  1  ID is stalled; branch operands not yet final
- pc_ID  in  PC_W  PC of the branch in ID
- taken_ID  in  1  actual direction
- target_ID  in  PC_W  actual target
- pred_taken_ID  in  1  prediction carried down the pipeline with this branch
- pred_target_ID  in  PC_W  predicted target carried down the pipeline
- mispredict_ID  out  1  redirect fetch; combinational
- redirect_pc_ID  out  PC_W  correct next PC: target_ID if taken, else pc_ID+4
- br_cnt  out  16  resolved-branch count
- mp_cnt  out  16  mispredict count

Behaviour:
- Address fields:
  - idx = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
  - Each entry holds valid, tag, ctr[1:0] and target.
- Reset (asynchronous, rst_n=0):
  - All valid=0, all ctr=2'b01, all targets/tags=0.
  - br_cnt=0, mp_cnt=0.
  - Combinational outputs follow from this state: pred_taken_IF=0, pred_target_IF=0.
  - Reset asserted mid-update discards that update.
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag match.
  - pred_taken_IF = hit && ctr[1].
  - pred_target_IF = stored target when pred_taken_IF=1, else 0.
- Update is qualified: upd = upd_en_ID && !stall_ID. It is written on the clk edge.
- On a hit:
  - taken: ctr increments, saturating at 2'b11; target is overwritten with target_ID.
  - not taken: ctr decrements, saturating at 2'b00; target is unchanged.
- On a miss:
  - taken: allocate — valid=1, tag written, target=target_ID, ctr=2'b10. Any previous occupant is replaced.
  - not taken: no allocation; the table is unchanged.
- Same-cycle lookup and update to one index: lookup returns the pre-update contents. There is no bypass; the new value is visible the next cycle.
- Mispredict, computed only when upd=1, otherwise 0:
  - mispredict_ID = (taken_ID != pred_taken_ID) || (taken_ID && pred_target_ID != target_ID).
  - redirect_pc_ID is valid whenever upd=1; its value is don't-care otherwise.
- Counters:
  - br_cnt += 1 on each upd.
  - mp_cnt += 1 on each upd with mispredict_ID=1.
  - Both wrap modulo 2**16.
- Stalls: while stall_ID=1, no table write, no counter change and no mispredict, regardless of upd_en_ID. A branch held for N stall cycles trains exactly once, in the first cycle with stall_ID=0.
- Adding 4 to pc_ID is modulo 2**PC_W.

Test Plan:
1. Reset:
   - Stimulus: pulse rst_n low between edges, then lookup pc_IF=0x100.
   - Required: pred_taken_IF=0, pred_target_IF=0, br_cnt=0, mp_cnt=0.
2. Allocate and saturate:
   - Stimulus: update pc_ID=0x100, taken=1, target=0x200, pred_taken_ID=0.
   - Required: mispredict_ID=1, redirect_pc_ID=0x200. Next cycle, lookup 0x100 gives pred_taken_IF=1 and target 0x200.
   - Stimulus: two more taken updates.
   - Required: ctr=11. Then three not-taken updates: after the first pred stays 1; after the second pred=0; the third saturates at 00.
3. Not-taken miss:
   - Stimulus: update pc_ID=0x300 with taken=0, pred_taken_ID=0.
   - Required: mispredict_ID=0, redirect_pc_ID=0x304, no allocation (lookup 0x300 gives pred 0), br_cnt increments.
4. Alias and target change:
   - Stimulus: train 0x100 taken, then taken update at 0x500 (same idx with IDX_W=4, different tag).
   - Required: 0x100 now misses. Separately, a taken update at 0x100 with pred_target_ID=0x200, target_ID=0x240 gives mispredict_ID=1 and a stored target of 0x240.
5. Stall gating:
   - Stimulus: upd_en_ID=1 with stall_ID=1 for 3 cycles, then stall_ID=0.
   - Required: mispredict_ID=0 during the stall, exactly one table write, br_cnt +1.
6. Same-cycle read/write and wrap:
   - Stimulus: lookup 0x100 in the allocating update cycle.
   - Required: old result (pred 0); pred 1 on the next cycle.
   - Stimulus: force 65536 updates.
   - Required: br_cnt wraps to 0.
